// File: rtl/ysyx_25040111_exu_sb.sv
// rtl/ysyx_25040111_exu_sb.sv - execute stage with counting RAW scoreboard and output FIFO
//
// One decoded op is accepted per handshake into S1, evaluated there in a single
// cycle, and pushed into an OBUF_DEPTH result FIFO toward the arbiter/LSU.
// Loads in flight are counted per destination register; readers and writers of
// a pending register are held off until ld_done retires enough loads.
//
// Optional: define YSYX_25040111_EXU_PERF_EN to add perf_stall / perf_full.
//
// Ports:
//   clock, reset            clock, synchronous active-low reset
//   in_valid/in_ready       decoded op handshake
//   in_cls, in_fn, in_immsel, in_rd, in_rs1, in_rs2, in_pc, in_imm, in_rs1v, in_rs2v
//                           decoded op fields and operand values
//   out_valid/out_ready     FIFO head handshake
//   out_cls, out_rd, out_res, out_wdata, out_gen
//                           head entry (zero when the FIFO is empty)
//   ld_done, ld_rd          load write-back completion
//   jump_valid, jump_pc     one-cycle redirect from S1
//   perf_stall, perf_full   hazard-stall / full-stall cycle counters (optional)

module ysyx_25040111_exu_sb #(
    parameter int XLEN       = 32,
    parameter int NREG       = 16,
    parameter int PEND_W     = 2,
    parameter int OBUF_DEPTH = 2,
    localparam int AW        = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_cls,
    input  logic [3:0]      in_fn,
    input  logic            in_immsel,
    input  logic [AW-1:0]   in_rd,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1v,
    input  logic [XLEN-1:0] in_rs2v,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_cls,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_res,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_gen,
    input  logic            ld_done,
    input  logic [AW-1:0]   ld_rd,
    output logic            jump_valid,
    output logic [XLEN-1:0] jump_pc
`ifdef YSYX_25040111_EXU_PERF_EN
    ,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_full
`endif
);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JAL    = 3'd4;
    localparam logic [2:0] CLS_JALR   = 3'd5;

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef struct packed {
        logic [2:0]      cls;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] wdata;
        logic            gen;
    } ent_t;

    // ------------------------------------------------------------------
    // Scoreboard and issue gating
    // ------------------------------------------------------------------
    logic [PEND_W-1:0] pend [NREG];

    logic          s1_valid;
    logic [CW-1:0] count;
    logic [CW-1:0] used;
    logic          lock;
    logic          space;
    logic          accept;
    logic          inc_en;
    logic          dec_en;

    // A load may stack on its own rd up to PEND_MAX; any other class must
    // wait for the register to drain so write-back order is preserved.
    assign lock = (pend[in_rs1] != '0)
                | (pend[in_rs2] != '0)
                | ((in_cls != CLS_LOAD) & (pend[in_rd] != '0))
                | ((in_cls == CLS_LOAD) & (pend[in_rd] == PEND_MAX));

    // The S1 op already owns a FIFO slot, so S1 never has to stall on push.
    assign used     = count + CW'(s1_valid);
    assign space    = used < CW'(OBUF_DEPTH);
    assign in_ready = reset & ~lock & space;
    assign accept   = in_valid & in_ready;

    assign inc_en = accept & (in_cls == CLS_LOAD) & (in_rd != '0);
    // Decrementing an empty counter is dropped rather than wrapping.
    assign dec_en = ld_done & (ld_rd != '0) & (pend[ld_rd] != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                pend[i] <= '0;
            end
        end else begin
            pend[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (inc_en && (in_rd == AW'(i)) && !(dec_en && (ld_rd == AW'(i)))) begin
                    pend[i] <= pend[i] + 1'b1;
                end else if (dec_en && (ld_rd == AW'(i)) && !(inc_en && (in_rd == AW'(i)))) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S1 register
    // ------------------------------------------------------------------
    logic [2:0]      s1_cls;
    logic [3:0]      s1_fn;
    logic            s1_immsel;
    logic [AW-1:0]   s1_rd;
    logic [XLEN-1:0] s1_pc;
    logic [XLEN-1:0] s1_imm;
    logic [XLEN-1:0] s1_rs1v;
    logic [XLEN-1:0] s1_rs2v;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_cls    <= '0;
            s1_fn     <= '0;
            s1_immsel <= 1'b0;
            s1_rd     <= '0;
            s1_pc     <= '0;
            s1_imm    <= '0;
            s1_rs1v   <= '0;
            s1_rs2v   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                // Reserved classes 6/7 are folded into ALU here once.
                s1_cls    <= (in_cls > CLS_JALR) ? CLS_ALU : in_cls;
                s1_fn     <= in_fn;
                s1_immsel <= in_immsel;
                s1_rd     <= in_rd;
                s1_pc     <= in_pc;
                s1_imm    <= in_imm;
                s1_rs1v   <= in_rs1v;
                s1_rs2v   <= in_rs2v;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1 evaluation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op2;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    logic            br_take;
    ent_t            s1_ent;

    assign op2    = s1_immsel ? s1_imm : s1_rs2v;
    assign shamt  = op2[4:0];
    assign addr   = s1_rs1v + s1_imm;
    assign link   = s1_pc + XLEN'(4);
    assign target = s1_pc + s1_imm;

    always_comb begin
        alu_res = s1_rs1v + op2;
        case (s1_fn)
            4'd0:    alu_res = s1_rs1v + op2;
            4'd1:    alu_res = s1_rs1v - op2;
            4'd2:    alu_res = s1_rs1v & op2;
            4'd3:    alu_res = s1_rs1v | op2;
            4'd4:    alu_res = s1_rs1v ^ op2;
            4'd5:    alu_res = s1_rs1v << shamt;
            4'd6:    alu_res = s1_rs1v >> shamt;
            4'd7:    alu_res = XLEN'($signed(s1_rs1v) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(s1_rs1v) < $signed(op2)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, s1_rs1v < op2};
            default: alu_res = s1_rs1v + op2;
        endcase
    end

    // Branches always compare rs1 against rs2; the immediate is the offset.
    always_comb begin
        br_take = 1'b0;
        case (s1_fn)
            4'd0:    br_take = (s1_rs1v == s1_rs2v);
            4'd1:    br_take = (s1_rs1v != s1_rs2v);
            4'd4:    br_take = ($signed(s1_rs1v) <  $signed(s1_rs2v));
            4'd5:    br_take = ($signed(s1_rs1v) >= $signed(s1_rs2v));
            4'd6:    br_take = (s1_rs1v <  s1_rs2v);
            4'd7:    br_take = (s1_rs1v >= s1_rs2v);
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        s1_ent       = '0;
        s1_ent.cls   = s1_cls;
        s1_ent.rd    = s1_rd;
        s1_ent.wdata = s1_rs2v;
        s1_ent.gen   = ((s1_cls == CLS_ALU) | (s1_cls == CLS_JAL) | (s1_cls == CLS_JALR))
                     & (s1_rd != '0);
        case (s1_cls)
            CLS_LOAD, CLS_STORE: s1_ent.res = addr;
            CLS_JAL, CLS_JALR:   s1_ent.res = link;
            CLS_BRANCH:          s1_ent.res = target;
            default:             s1_ent.res = alu_res;
        endcase
    end

    always_comb begin
        jump_valid = 1'b0;
        jump_pc    = '0;
        if (reset && s1_valid) begin
            case (s1_cls)
                CLS_JAL: begin
                    jump_valid = 1'b1;
                    jump_pc    = target;
                end
                CLS_JALR: begin
                    jump_valid = 1'b1;
                    jump_pc    = {addr[XLEN-1:1], 1'b0};
                end
                CLS_BRANCH: begin
                    jump_valid = br_take;
                    jump_pc    = br_take ? target : '0;
                end
                default: begin
                    jump_valid = 1'b0;
                    jump_pc    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    ent_t          mem [OBUF_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;
    ent_t          head;

    assign push = s1_valid;
    assign pop  = out_valid & out_ready;
    assign head = mem[rptr];

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wptr] <= s1_ent;
        end
    end

    // OBUF_DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = reset & (count != '0);
    assign out_cls   = out_valid ? head.cls   : '0;
    assign out_rd    = out_valid ? head.rd    : '0;
    assign out_res   = out_valid ? head.res   : '0;
    assign out_wdata = out_valid ? head.wdata : '0;
    assign out_gen   = out_valid ? head.gen   : 1'b0;

    // A load completion must always match an outstanding load.
    assert property (@(posedge clock) disable iff (!reset)
        (ld_done && (ld_rd != '0)) |-> (pend[ld_rd] != '0));

`ifdef YSYX_25040111_EXU_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_stall <= '0;
            perf_full  <= '0;
        end else begin
            if (in_valid && lock) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (in_valid && !lock && !in_ready) begin
                perf_full <= perf_full + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25040111_exu_sb.sv
// tb/tb_ysyx_25040111_exu_sb.sv - directed self-checking bench for ysyx_25040111_exu_sb

module tb_ysyx_25040111_exu_sb;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_cls;
    logic [3:0]  in_fn;
    logic        in_immsel;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_rs1v;
    logic [31:0] in_rs2v;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_cls;
    logic [3:0]  out_rd;
    logic [31:0] out_res;
    logic [31:0] out_wdata;
    logic        out_gen;
    logic        ld_done;
    logic [3:0]  ld_rd;
    logic        jump_valid;
    logic [31:0] jump_pc;
`ifdef YSYX_25040111_EXU_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_full;
`endif

    int checks = 0;
    int errors = 0;

    ysyx_25040111_exu_sb dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cls     (in_cls),
        .in_fn      (in_fn),
        .in_immsel  (in_immsel),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_pc      (in_pc),
        .in_imm     (in_imm),
        .in_rs1v    (in_rs1v),
        .in_rs2v    (in_rs2v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cls    (out_cls),
        .out_rd     (out_rd),
        .out_res    (out_res),
        .out_wdata  (out_wdata),
        .out_gen    (out_gen),
        .ld_done    (ld_done),
        .ld_rd      (ld_rd),
        .jump_valid (jump_valid),
        .jump_pc    (jump_pc)
`ifdef YSYX_25040111_EXU_PERF_EN
        ,
        .perf_stall (perf_stall),
        .perf_full  (perf_full)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] cls, input logic [3:0] fn, input logic immsel,
                            input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1v, input logic [31:0] rs2v);
        in_cls    = cls;
        in_fn     = fn;
        in_immsel = immsel;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_pc     = pc;
        in_imm    = imm;
        in_rs1v   = rs1v;
        in_rs2v   = rs2v;
        in_valid  = 1'b1;
    endtask

    // Waits (bounded) for in_ready, takes the accepting edge, and returns
    // 1 ns after that edge with in_valid dropped: i.e. in the S1 cycle.
    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) step();
        in_valid = 1'b0;
        chk(tag, ok, 1);
    endtask

    task automatic issue(input string tag, input logic [2:0] cls, input logic [3:0] fn,
                         input logic immsel, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1v, input logic [31:0] rs2v);
        drive_op(cls, fn, immsel, rd, rs1, rs2, pc, imm, rs1v, rs2v);
        wait_accept(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic pulse_ld(input logic [3:0] r);
        ld_done = 1'b1;
        ld_rd   = r;
        step();
        ld_done = 1'b0;
        ld_rd   = '0;
    endtask

    // ALU vectors: fn, rs1v, imm (immsel=1), expected result
    logic [3:0]  v_fn  [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [31:0] v_a   [9] = '{32'd10, 32'hF0F0_F0F0, 32'hF000_0000, 32'h0000_00FF, 32'd1,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] v_b   [9] = '{32'd3, 32'h0FF0_0FF0, 32'h0000_000F, 32'h0000_000F, 32'h24,
                               32'd4, 32'd4, 32'd1, 32'd1};
    logic [31:0] v_exp [9] = '{32'd7, 32'h00F0_00F0, 32'hF000_000F, 32'h0000_00F0, 32'h10,
                               32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ld_done = 1'b0; ld_rd = '0;
        drive_op(3'd0, 4'd0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        in_valid = 1'b0;
        step(); step(); step();
        in_valid = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_jump_valid", jump_valid, 0);
        chk("rst_out_res", out_res, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();

        // ALU ADD with 2-cycle latency
        drive_op(3'd0, 4'd0, 1'b1, 4'd3, 4'd1, 4'd0, '0, 32'd7, 32'd5, '0);
        #1 chk("add_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1 chk("add_s1_no_out", out_valid, 0);
        step();
        chk("add_valid", out_valid, 1);
        chk("add_res", out_res, 12);
        chk("add_gen", out_gen, 1);
        chk("add_rd", out_rd, 3);
        chk("add_cls", out_cls, 0);
        step();
        chk("add_popped", out_valid, 0);

        // ALU function table
        for (int i = 0; i < 9; i++) begin
            issue("alu_acc", 3'd0, v_fn[i], 1'b1, 4'd2, 4'd1, 4'd0, '0, v_b[i], v_a[i], '0);
            step();
            chk($sformatf("alu_fn%0d", v_fn[i]), out_res, v_exp[i]);
            step();
        end

        // STORE / JAL / JALR
        issue("st_acc", 3'd2, 4'd0, 1'b1, 4'd0, 4'd1, 4'd2, '0, 32'h20, 32'h1000, 32'hDEAD_BEEF);
        #1 chk("st_no_jump", jump_valid, 0);
        step();
        chk("st_res", out_res, 32'h1020);
        chk("st_wdata", out_wdata, 32'hDEAD_BEEF);
        chk("st_gen", out_gen, 0);
        drain();
        issue("jal_acc", 3'd4, 4'd0, 1'b1, 4'd1, 4'd0, 4'd0, 32'h100, 32'h40, '0, '0);
        #1 chk("jal_jump", jump_valid, 1);
        chk("jal_pc", jump_pc, 32'h140);
        step();
        chk("jal_pulse_end", jump_valid, 0);
        chk("jal_link", out_res, 32'h104);
        chk("jal_gen", out_gen, 1);
        drain();
        issue("jalr_acc", 3'd5, 4'd0, 1'b1, 4'd0, 4'd1, 4'd0, 32'h100, 32'h10, 32'h201, '0);
        #1 chk("jalr_pc", jump_pc, 32'h210);
        step();
        chk("jalr_gen_rd0", out_gen, 0);
        drain();

        // RAW hazard on a pending load
        issue("ld4_acc", 3'd1, 4'd0, 1'b1, 4'd4, 4'd1, 4'd0, '0, 32'd4, 32'h100, '0);
        step();
        chk("ld4_res", out_res, 32'h104);
        chk("ld4_cls", out_cls, 1);
        chk("ld4_gen", out_gen, 0);
        drain();
        drive_op(3'd0, 4'd0, 1'b1, 4'd7, 4'd4, 4'd0, '0, 32'd2, 32'd1, '0);
        #1 chk("raw_locked", in_ready, 0);
        step(); step();
        chk("raw_still_locked", in_ready, 0);
        ld_done = 1'b1; ld_rd = 4'd4;
        #1 chk("raw_locked_done_cycle", in_ready, 0);
        step();
        ld_done = 1'b0; ld_rd = '0;
        #1 chk("raw_released", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        chk("raw_add_res", out_res, 3);
        drain();

        // Counting scoreboard on rd=5 (max 3 outstanding)
        for (int i = 0; i < 3; i++) begin
            issue("cnt_ld_acc", 3'd1, 4'd0, 1'b1, 4'd5, 4'd0, 4'd0, '0, '0, '0, '0);
        end
        drain();
        drive_op(3'd1, 4'd0, 1'b1, 4'd5, 4'd0, 4'd0, '0, '0, '0, '0);
        #1 chk("cnt_ld4_locked", in_ready, 0);
        ld_done = 1'b1; ld_rd = 4'd5;
        step();
        ld_done = 1'b0; ld_rd = '0;
        #1 chk("cnt_ld4_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        drain();
        drive_op(3'd1, 4'd0, 1'b1, 4'd5, 4'd0, 4'd0, '0, '0, '0, '0);
        #1 chk("cnt_full_again", in_ready, 0);
        in_valid = 1'b0;
        pulse_ld(4'd5);
        drive_op(3'd1, 4'd0, 1'b1, 4'd5, 4'd0, 4'd0, '0, '0, '0, '0);
        ld_done = 1'b1; ld_rd = 4'd5;
        #1 chk("cnt_same_cycle_ready", in_ready, 1);
        step();
        in_valid = 1'b0; ld_done = 1'b0; ld_rd = '0;
        drain();
        pulse_ld(4'd0);
        drive_op(3'd1, 4'd0, 1'b1, 4'd5, 4'd0, 4'd0, '0, '0, '0, '0);
        #1 chk("cnt_after_same_lo", in_ready, 1);
        step();
        in_valid = 1'b0;
        drain();
        drive_op(3'd1, 4'd0, 1'b1, 4'd5, 4'd0, 4'd0, '0, '0, '0, '0);
        #1 chk("cnt_after_same_hi", in_ready, 0);
        in_valid = 1'b0;
        pulse_ld(4'd5);
        pulse_ld(4'd5);
        drive_op(3'd0, 4'd0, 1'b1, 4'd7, 4'd5, 4'd0, '0, '0, '0, '0);
        #1 chk("cnt_one_left", in_ready, 0);
        in_valid = 1'b0;
        pulse_ld(4'd5);
        drive_op(3'd0, 4'd0, 1'b1, 4'd7, 4'd5, 4'd0, '0, '0, '0, '0);
        #1 chk("cnt_cleared", in_ready, 1);
        in_valid = 1'b0;
        drain();

        // Branches
        issue("blt_acc", 3'd3, 4'd4, 1'b0, 4'd0, 4'd1, 4'd2, 32'h8000_0000, 32'h10,
              32'hFFFF_FFFF, 32'd1);
        #1 chk("blt_jump", jump_valid, 1);
        chk("blt_pc", jump_pc, 32'h8000_0010);
        step();
        chk("blt_pulse_end", jump_valid, 0);
        chk("blt_entry_cls", out_cls, 3);
        chk("blt_entry_gen", out_gen, 0);
        drain();
        issue("bge_acc", 3'd3, 4'd5, 1'b0, 4'd0, 4'd1, 4'd2, 32'h8000_0000, 32'h10,
              32'hFFFF_FFFF, 32'd1);
        #1 chk("bge_no_jump", jump_valid, 0);
        drain();
        issue("bltu_acc", 3'd3, 4'd6, 1'b0, 4'd0, 4'd1, 4'd2, 32'h8000_0000, 32'h10,
              32'hFFFF_FFFF, 32'd1);
        #1 chk("bltu_no_jump", jump_valid, 0);
        drain();

        // Backpressure with a 2-entry FIFO
        out_ready = 1'b0;
        drive_op(3'd0, 4'd1, 1'b0, 4'd2, 4'd1, 4'd2, '0, '0, 32'd10, 32'd3);
        #1 chk("bp_a_ready", in_ready, 1);
        step();
        drive_op(3'd0, 4'd4, 1'b1, 4'd3, 4'd1, 4'd0, '0, 32'h0F, 32'hFF, '0);
        #1 chk("bp_b_ready", in_ready, 1);
        step();
        drive_op(3'd0, 4'd7, 1'b1, 4'd6, 4'd1, 4'd0, '0, 32'd4, 32'h8000_0000, '0);
        #1 chk("bp_c_stall", in_ready, 0);
        step();
        chk("bp_c_stall_full", in_ready, 0);
        chk("bp_head_a", out_res, 7);
        step();
        chk("bp_head_a_held", out_res, 7);
        out_ready = 1'b1;
        step();
        chk("bp_head_b", out_res, 32'hF0);
        chk("bp_c_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_empty_gap", out_valid, 0);
        step();
        chk("bp_head_c", out_res, 32'hF800_0000);
        chk("bp_head_c_rd", out_rd, 6);
        drain();

        // No jump pulse in a reset cycle
        issue("jal_rst_acc", 3'd4, 4'd0, 1'b1, 4'd1, 4'd0, 4'd0, 32'h100, 32'h40, '0, '0);
        reset = 1'b0;
        #1 chk("rst_no_jump", jump_valid, 0);
        step();
        reset = 1'b1;
        step();
        chk("rst_jal_dropped", out_valid, 0);

        // Reset with a pending load and a full FIFO
        issue("rst_ld_acc", 3'd1, 4'd0, 1'b1, 4'd6, 4'd0, 4'd0, '0, '0, '0, '0);
        drain();
        out_ready = 1'b0;
        issue("rst_a_acc", 3'd0, 4'd0, 1'b1, 4'd7, 4'd1, 4'd0, '0, 32'd1, 32'd1, '0);
        issue("rst_b_acc", 3'd0, 4'd0, 1'b1, 4'd8, 4'd2, 4'd0, '0, 32'd2, 32'd2, '0);
        step();
        chk("rst_fifo_full", out_valid, 1);
        reset = 1'b0;
        step();
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        reset = 1'b1;
        out_ready = 1'b1;
        drive_op(3'd0, 4'd0, 1'b1, 4'd9, 4'd6, 4'd0, '0, 32'd1, 32'h40, '0);
        #1 chk("rst_raw_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        chk("rst_add_valid", out_valid, 1);
        chk("rst_add_res", out_res, 32'h41);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
